// File: rtl/rv_defs.sv
// Shared constants for the RV data-memory arbiter: FSM encoding and debug fairness limit.
package rv_defs;
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CORE = 2'd1,
      ARB_DBG  = 2'd2
   } arb_state_t;

   localparam logic [2:0] FAIR_LIMIT = 3'd4;
   localparam logic [3:0] DBG_BSEL   = 4'b1111;
endpackage

// File: rtl/rv_dmem_arb.sv
// Core/debug arbiter for a single data-memory port: one access in flight,
// core priority with a debug fairness escape, and a watchdog abort on missing acks.
module rv_dmem_arb
   import rv_defs::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] c_addr_i,
   input  logic [31:0] c_data_s_i,
   input  logic [3:0]  c_bsel_i,
   input  logic        c_load_i,
   input  logic        c_store_i,
   output logic [31:0] c_data_l_o,
   output logic        c_load_done_o,
   output logic        c_store_done_o,
   input  logic        d_req_i,
   input  logic        d_we_i,
   input  logic [31:0] d_addr_i,
   input  logic [31:0] d_data_i,
   output logic [31:0] d_data_o,
   output logic        d_ack_o,
   output logic [31:0] m_addr_o,
   output logic [31:0] m_data_o,
   output logic [3:0]  m_bsel_o,
   output logic        m_load_o,
   output logic        m_store_o,
   input  logic [31:0] m_data_i,
   input  logic        m_ack_i,
   output logic        err_o
);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   arb_state_t  state_reg, state_next;
   logic        buf_valid_reg, buf_valid_next;
   logic [31:0] buf_addr_reg, buf_addr_next;
   logic [31:0] buf_data_reg, buf_data_next;
   logic [3:0]  buf_bsel_reg, buf_bsel_next;
   logic        buf_store_reg, buf_store_next;
   logic [2:0]  fair_cnt_reg, fair_cnt_next;
   logic [7:0]  timer_reg, timer_next;
   logic [31:0] m_addr_reg, m_addr_next;
   logic [31:0] m_data_reg, m_data_next;
   logic [3:0]  m_bsel_reg, m_bsel_next;
   logic        m_load_reg, m_load_next;
   logic        m_store_reg, m_store_next;
   logic        err_reg, err_next;
   logic        to_cload_reg, to_cload_next;
   logic        to_cstore_reg, to_cstore_next;
   logic        to_dbg_reg, to_dbg_next;

   logic        strobe_take, core_avail, sel_store;
   logic        grant_core, grant_dbg, busy, timed_out, core_ack, dbg_ack;
   logic [31:0] sel_addr, sel_data;
   logic [3:0]  sel_bsel;

   // A strobe seen while idle is granted straight away, bypassing the buffer.
   always_comb begin
      strobe_take = (c_load_i | c_store_i) & ~buf_valid_reg;
      core_avail  = buf_valid_reg | strobe_take;
      sel_addr    = buf_valid_reg ? buf_addr_reg  : c_addr_i;
      sel_data    = buf_valid_reg ? buf_data_reg  : c_data_s_i;
      sel_bsel    = buf_valid_reg ? buf_bsel_reg  : c_bsel_i;
      sel_store   = buf_valid_reg ? buf_store_reg : (c_store_i & ~c_load_i);
      grant_core  = (state_reg == ARB_IDLE) & core_avail
                    & ~((fair_cnt_reg == FAIR_LIMIT) & d_req_i);
      grant_dbg   = (state_reg == ARB_IDLE) & d_req_i & ~grant_core;
      busy        = (state_reg != ARB_IDLE);
      timed_out   = busy & ~m_ack_i & (timer_reg == TO_LAST);
   end

   always_comb begin
      state_next     = state_reg;
      buf_valid_next = buf_valid_reg;
      buf_addr_next  = buf_addr_reg;
      buf_data_next  = buf_data_reg;
      buf_bsel_next  = buf_bsel_reg;
      buf_store_next = buf_store_reg;
      fair_cnt_next  = fair_cnt_reg;
      timer_next     = busy ? timer_reg + 8'd1 : 8'd0;
      m_addr_next    = m_addr_reg;
      m_data_next    = m_data_reg;
      m_bsel_next    = m_bsel_reg;
      m_load_next    = m_load_reg;
      m_store_next   = m_store_reg;
      err_next       = 1'b0;
      to_cload_next  = 1'b0;
      to_cstore_next = 1'b0;
      to_dbg_next    = 1'b0;

      if (grant_core) begin
         buf_valid_next = 1'b0;
      end else if (strobe_take) begin
         buf_valid_next = 1'b1;
         buf_addr_next  = c_addr_i;
         buf_data_next  = c_data_s_i;
         buf_bsel_next  = c_bsel_i;
         buf_store_next = c_store_i & ~c_load_i;
      end

      case (state_reg)
         ARB_IDLE: begin
            if (grant_core) begin
               state_next    = ARB_CORE;
               m_addr_next   = sel_addr;
               m_data_next   = sel_data;
               m_bsel_next   = sel_bsel;
               m_load_next   = ~sel_store;
               m_store_next  = sel_store;
               fair_cnt_next = d_req_i ? fair_cnt_reg + 3'd1 : 3'd0;
            end else if (grant_dbg) begin
               state_next    = ARB_DBG;
               m_addr_next   = d_addr_i;
               m_data_next   = d_data_i;
               m_bsel_next   = DBG_BSEL;
               m_load_next   = ~d_we_i;
               m_store_next  = d_we_i;
               fair_cnt_next = 3'd0;
            end
         end
         ARB_CORE, ARB_DBG: begin
            if (m_ack_i) begin
               state_next   = ARB_IDLE;
               m_load_next  = 1'b0;
               m_store_next = 1'b0;
            end else if (timed_out) begin
               state_next     = ARB_IDLE;
               m_load_next    = 1'b0;
               m_store_next   = 1'b0;
               err_next       = 1'b1;
               to_cload_next  = (state_reg == ARB_CORE) & ~m_store_reg;
               to_cstore_next = (state_reg == ARB_CORE) & m_store_reg;
               to_dbg_next    = (state_reg == ARB_DBG);
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= ARB_IDLE;
         buf_valid_reg <= 1'b0;
         buf_addr_reg  <= 32'h0;
         buf_data_reg  <= 32'h0;
         buf_bsel_reg  <= 4'h0;
         buf_store_reg <= 1'b0;
         fair_cnt_reg  <= 3'd0;
         timer_reg     <= 8'd0;
         m_addr_reg    <= 32'h0;
         m_data_reg    <= 32'h0;
         m_bsel_reg    <= 4'h0;
         m_load_reg    <= 1'b0;
         m_store_reg   <= 1'b0;
         err_reg       <= 1'b0;
         to_cload_reg  <= 1'b0;
         to_cstore_reg <= 1'b0;
         to_dbg_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         buf_valid_reg <= buf_valid_next;
         buf_addr_reg  <= buf_addr_next;
         buf_data_reg  <= buf_data_next;
         buf_bsel_reg  <= buf_bsel_next;
         buf_store_reg <= buf_store_next;
         fair_cnt_reg  <= fair_cnt_next;
         timer_reg     <= timer_next;
         m_addr_reg    <= m_addr_next;
         m_data_reg    <= m_data_next;
         m_bsel_reg    <= m_bsel_next;
         m_load_reg    <= m_load_next;
         m_store_reg   <= m_store_next;
         err_reg       <= err_next;
         to_cload_reg  <= to_cload_next;
         to_cstore_reg <= to_cstore_next;
         to_dbg_reg    <= to_dbg_next;
      end
   end

   // Completions are combinational on the ack; an abort completes one cycle later with zero data.
   assign core_ack       = ~rst_i & m_ack_i & (state_reg == ARB_CORE);
   assign dbg_ack        = ~rst_i & m_ack_i & (state_reg == ARB_DBG);
   assign c_load_done_o  = (core_ack & ~m_store_reg) | (~rst_i & to_cload_reg);
   assign c_store_done_o = (core_ack & m_store_reg) | (~rst_i & to_cstore_reg);
   assign d_ack_o        = dbg_ack | (~rst_i & to_dbg_reg);
   assign c_data_l_o     = err_reg ? 32'h0 : m_data_i;
   assign d_data_o       = err_reg ? 32'h0 : m_data_i;
   assign err_o          = err_reg;
   assign m_addr_o       = m_addr_reg;
   assign m_data_o       = m_data_reg;
   assign m_bsel_o       = m_bsel_reg;
   assign m_load_o       = m_load_reg;
   assign m_store_o      = m_store_reg;
endmodule

// File: tb/tb_rv_dmem_arb.sv
// Scoreboard bench for rv_dmem_arb: expected issues and completions are queued by
// each scenario and consumed by a bus monitor; a responder models the memory.
module tb_rv_dmem_arb;
   localparam int          TO  = 8;
   localparam logic [31:0] PAT = 32'h5A5A_5A5A;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] c_addr_i, c_data_s_i, c_data_l_o;
   logic [3:0]  c_bsel_i;
   logic        c_load_i, c_store_i, c_load_done_o, c_store_done_o;
   logic        d_req_i, d_we_i, d_ack_o;
   logic [31:0] d_addr_i, d_data_i, d_data_o;
   logic [31:0] m_addr_o, m_data_o, m_data_i;
   logic [3:0]  m_bsel_o;
   logic        m_load_o, m_store_o, m_ack_i, err_o;

   rv_dmem_arb #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .c_addr_i(c_addr_i), .c_data_s_i(c_data_s_i), .c_bsel_i(c_bsel_i),
      .c_load_i(c_load_i), .c_store_i(c_store_i), .c_data_l_o(c_data_l_o),
      .c_load_done_o(c_load_done_o), .c_store_done_o(c_store_done_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
      .d_data_o(d_data_o), .d_ack_o(d_ack_o),
      .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_bsel_o(m_bsel_o),
      .m_load_o(m_load_o), .m_store_o(m_store_o), .m_data_i(m_data_i),
      .m_ack_i(m_ack_i), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        dbg;
      logic        store;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  bsel;
   } iss_t;
   typedef struct {
      logic        dbg;
      logic        store;
      logic [31:0] data;
      logic        err;
   } done_t;

   iss_t  issue_q[$];
   done_t done_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic [31:0] mem [logic [31:0]];
   int    ack_lat = 2;
   bit    mem_hang = 0;
   bit    stray_ack = 0;
   int    age = 0;
   bit    in_req = 0;
   // monitor bookkeeping
   bit    mon_prev_req = 0;
   int    req_len = 0, last_req_len = 0;
   int    last_rise_cyc = 0, dbg_rise_cyc = 0, core_done_cyc = 0, err_cyc = 0;
   int    d_ack_cnt = 0, cst_cnt = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ PAT;
   endfunction

   // Memory responder: acks after ack_lat cycles of a held request, garbage data otherwise.
   initial forever begin
      @(posedge clk_i);
      #1;
      m_ack_i  = 1'b0;
      m_data_i = 32'hBAD0_BAD0;
      if (m_load_o || m_store_o) begin
         age    = in_req ? age + 1 : 0;
         in_req = 1;
         if (!mem_hang && age == ack_lat) begin
            m_ack_i = 1'b1;
            if (m_store_o) mem[m_addr_o] = merge(mem_rd(m_addr_o), m_data_o, m_bsel_o);
            else           m_data_i = mem_rd(m_addr_o);
         end
      end else begin
         in_req = 0;
         if (stray_ack) begin
            m_ack_i   = 1'b1;
            m_data_i  = 32'h1234_5678;
            stray_ack = 0;
         end
      end
   end

   // Bus monitor: pops the issue queue on each request rise and the done queue on each completion.
   initial forever begin
      iss_t  e;
      done_t d;
      logic  req;
      logic [2:0]  dv, ev;
      logic [31:0] dact;
      @(negedge clk_i);
      req = m_load_o | m_store_o;
      if (req && !mon_prev_req) begin
         checks++;
         if (issue_q.size() == 0) begin
            errors++;
            $display("FAIL issue: unexpected request addr=%h load=%b store=%b, required none",
                     m_addr_o, m_load_o, m_store_o);
         end else begin
            e = issue_q.pop_front();
            if (m_load_o !== ~e.store || m_store_o !== e.store || m_addr_o !== e.addr ||
                m_bsel_o !== e.bsel || (e.store && m_data_o !== e.data)) begin
               errors++;
               $display("FAIL issue: got ld=%b st=%b addr=%h data=%h bsel=%h, required st=%b addr=%h data=%h bsel=%h",
                        m_load_o, m_store_o, m_addr_o, m_data_o, m_bsel_o, e.store, e.addr, e.data, e.bsel);
            end
            last_rise_cyc = cyc;
            if (e.dbg) dbg_rise_cyc = cyc;
         end
         req_len = 1;
      end else if (req) begin
         req_len++;
      end
      if (!req && mon_prev_req) last_req_len = req_len;
      mon_prev_req = req;

      dv = {d_ack_o, c_store_done_o, c_load_done_o};
      if (d_ack_o) d_ack_cnt++;
      if (c_store_done_o) cst_cnt++;
      if (err_o) err_cyc = cyc;
      if (dv != 3'b000) begin
         checks++;
         if (done_q.size() == 0) begin
            errors++;
            $display("FAIL completion: unexpected done vector %b err=%b, required none", dv, err_o);
         end else begin
            d    = done_q.pop_front();
            ev   = d.dbg ? 3'b100 : (d.store ? 3'b010 : 3'b001);
            dact = d.dbg ? d_data_o : c_data_l_o;
            if (dv !== ev || err_o !== d.err || (!d.store && dact !== d.data)) begin
               errors++;
               $display("FAIL completion: got done=%b err=%b data=%h, required done=%b err=%b data=%h",
                        dv, err_o, dact, ev, d.err, d.data);
            end
            if (!d.dbg) core_done_cyc = cyc;
         end
      end else if (err_o) begin
         checks++;
         errors++;
         $display("FAIL err_pulse: err_o=1 with no completion, required done with err");
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic push_iss(input logic dbg, input logic st, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
      iss_t e;
      e.dbg = dbg; e.store = st; e.addr = a; e.data = d; e.bsel = be;
      issue_q.push_back(e);
   endtask

   task automatic push_done(input logic dbg, input logic st, input logic [31:0] d, input logic er);
      done_t x;
      x.dbg = dbg; x.store = st; x.data = d; x.err = er;
      done_q.push_back(x);
   endtask

   task automatic core_strobe(input logic ld, input logic st, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
      c_load_i = ld; c_store_i = st; c_addr_i = a; c_data_s_i = d; c_bsel_i = be;
      tick();
      c_load_i = 1'b0; c_store_i = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((issue_q.size() != 0 || done_q.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (issue_q.size() != 0 || done_q.size() != 0) begin
         errors++;
         $display("FAIL %s drain: pending issue=%0d done=%0d, required 0/0",
                  name, issue_q.size(), done_q.size());
         issue_q.delete();
         done_q.delete();
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
      checks++;
      if ({m_load_o, m_store_o, err_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: got ld/st/err=%b%b%b, required 000", m_load_o, m_store_o, err_o);
      end
      checks++;
      if (m_addr_o !== 32'h0 || m_data_o !== 32'h0 || m_bsel_o !== 4'h0) begin
         errors++;
         $display("FAIL reset_bus: got addr=%h data=%h bsel=%h, required 0", m_addr_o, m_data_o, m_bsel_o);
      end
      checks++;
      if ({c_load_done_o, c_store_done_o, d_ack_o} !== 3'b000) begin
         errors++;
         $display("FAIL reset_done: got %b%b%b, required 000", c_load_done_o, c_store_done_o, d_ack_o);
      end
      $display("test_reset done");
   endtask

   task automatic test_core_load();
      int s;
      mem[32'h100] = 32'hDEAD_BEEF;
      ack_lat = 2;
      push_iss(0, 0, 32'h100, 32'h0, 4'hF);
      push_done(0, 0, 32'hDEAD_BEEF, 0);
      s = cyc;
      core_strobe(1, 0, 32'h100, 32'h0, 4'hF);
      drain("core_load");
      checks++;
      if (last_rise_cyc !== s + 1) begin
         errors++;
         $display("FAIL core_load_latency: rise cycle %0d, required %0d", last_rise_cyc, s + 1);
      end
      checks++;
      if (last_req_len !== 3) begin
         errors++;
         $display("FAIL core_load_len: m_load_o high %0d cycles, required 3", last_req_len);
      end
      $display("test_core_load done: data DEADBEEF at 0x100");
   endtask

   task automatic test_core_dbg_same();
      int n, a0;
      logic [31:0] exp_rd;
      ack_lat = 1;
      exp_rd = merge(32'h200 ^ PAT, 32'h1122_3344, 4'b0011);
      push_iss(0, 1, 32'h200, 32'h1122_3344, 4'b0011);
      push_iss(1, 0, 32'h200, 32'h0, 4'hF);
      push_done(0, 1, 32'h0, 0);
      push_done(1, 0, exp_rd, 0);
      a0 = d_ack_cnt;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_data_i = 32'h0;
      core_strobe(0, 1, 32'h200, 32'h1122_3344, 4'b0011);
      n = 0;
      while (!d_ack_o && n < 100) begin
         tick();
         n++;
      end
      d_req_i = 1'b0;
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL dbg_same_wait: no d_ack_o within 100 cycles, required ack");
      end
      drain("core_dbg_same");
      checks++;
      if (dbg_rise_cyc !== core_done_cyc + 2) begin
         errors++;
         $display("FAIL dbg_after_core: dbg rise cycle %0d, required %0d", dbg_rise_cyc, core_done_cyc + 2);
      end
      checks++;
      if (d_ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL dbg_ack_count: got %0d acks, required 1", d_ack_cnt - a0);
      end
      $display("test_core_dbg_same done: dbg read %h", exp_rd);
   endtask

   task automatic test_back_to_back();
      int n, a0;
      logic [31:0] a;
      ack_lat = 0;
      a0 = d_ack_cnt;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) begin
            push_iss(1, 1, 32'h3F0, 32'hCAFE_F00D, 4'hF);
            push_done(1, 1, 32'h0, 0);
         end
         push_iss(0, 1, 32'h300 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
         push_done(0, 1, 32'h0, 0);
      end
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h3F0; d_data_i = 32'hCAFE_F00D;
      for (int i = 0; i < 6; i++) begin
         a = 32'h300 + 32'(4 * i);
         core_strobe(0, 1, a, 32'hA000_0000 + 32'(i), 4'hF);
         n = 0;
         while (!(m_store_o && m_addr_o == a) && n < 50) begin
            tick();
            if (d_ack_o) d_req_i = 1'b0;
            n++;
         end
         checks++;
         if (n >= 50) begin
            errors++;
            $display("FAIL b2b_issue_wait: store %0d not issued within 50 cycles, required issue", i);
         end
      end
      d_req_i = 1'b0;
      drain("back_to_back");
      checks++;
      if (d_ack_cnt - a0 !== 1) begin
         errors++;
         $display("FAIL b2b_dbg_acks: got %0d, required 1", d_ack_cnt - a0);
      end
      $display("test_back_to_back done: 6 core stores with one debug write");
   endtask

   task automatic test_ack_cycle_strobe();
      int n, ack_c;
      ack_lat = 0;
      push_iss(0, 0, 32'h600, 32'h0, 4'hF);
      push_done(0, 0, 32'h600 ^ PAT, 0);
      push_iss(0, 0, 32'h100, 32'h0, 4'h3);
      push_done(0, 0, 32'hDEAD_BEEF, 0);
      core_strobe(1, 0, 32'h600, 32'h0, 4'hF);
      n = 0;
      while (!c_load_done_o && n < 50) begin
         tick();
         n++;
      end
      ack_c = cyc;
      core_strobe(1, 1, 32'h100, 32'h5555_5555, 4'h3);
      drain("ack_cycle_strobe");
      checks++;
      if (last_rise_cyc !== ack_c + 2) begin
         errors++;
         $display("FAIL ack_cycle_strobe: second rise cycle %0d, required %0d", last_rise_cyc, ack_c + 2);
      end
      $display("test_ack_cycle_strobe done");
   endtask

   task automatic test_stray_ack();
      stray_ack = 1;
      tick();
      checks++;
      if ({c_load_done_o, c_store_done_o, d_ack_o, err_o} !== 4'b0000) begin
         errors++;
         $display("FAIL stray_ack: got done/ack/err %b%b%b%b, required 0000",
                  c_load_done_o, c_store_done_o, d_ack_o, err_o);
      end
      tick();
      $display("test_stray_ack done");
   endtask

   task automatic test_timeout();
      int n, e_c;
      mem_hang = 1;
      push_iss(0, 0, 32'h400, 32'h0, 4'hF);
      push_done(0, 0, 32'h0, 1);
      core_strobe(1, 0, 32'h400, 32'h0, 4'hF);
      n = 0;
      while (!err_o && n < 40) begin
         tick();
         n++;
      end
      e_c = cyc;
      checks++;
      if (n >= 40 || m_load_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: err seen=%b m_load_o=%b, required err=1 m_load_o=0", err_o, m_load_o);
      end
      mem_hang = 0;
      drain("timeout");
      checks++;
      if (e_c - last_rise_cyc !== TO) begin
         errors++;
         $display("FAIL timeout_cycles: err %0d cycles after rise, required %0d", e_c - last_rise_cyc, TO);
      end
      $display("test_timeout done");
   endtask

   task automatic test_reset_mid();
      int c0;
      ack_lat = 5;
      c0 = cst_cnt;
      push_iss(0, 1, 32'h500, 32'h0000_0077, 4'hF);
      core_strobe(0, 1, 32'h500, 32'h0000_0077, 4'hF);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      checks++;
      if ({m_load_o, m_store_o} !== 2'b00 || m_addr_o !== 32'h0 || m_data_o !== 32'h0 || m_bsel_o !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_bus: got ld=%b st=%b addr=%h data=%h bsel=%h, required all 0",
                  m_load_o, m_store_o, m_addr_o, m_data_o, m_bsel_o);
      end
      repeat (8) tick();
      checks++;
      if (cst_cnt - c0 !== 0) begin
         errors++;
         $display("FAIL reset_mid_done: got %0d store dones, required 0", cst_cnt - c0);
      end
      ack_lat = 2;
      push_iss(0, 0, 32'h100, 32'h0, 4'hF);
      push_done(0, 0, 32'hDEAD_BEEF, 0);
      core_strobe(1, 0, 32'h100, 32'h0, 4'hF);
      drain("reset_mid_reload");
      $display("test_reset_mid done");
   endtask

   initial begin
      rst_i = 1'b1;
      c_addr_i = 32'h0; c_data_s_i = 32'h0; c_bsel_i = 4'h0;
      c_load_i = 1'b0; c_store_i = 1'b0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'h0; d_data_i = 32'h0;
      m_ack_i = 1'b0; m_data_i = 32'h0;
      test_reset();
      test_core_load();
      test_core_dbg_same();
      test_back_to_back();
      test_ack_cycle_strobe();
      test_stray_ack();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time, required completion");
      $fatal(1, "watchdog expired");
   end
endmodule
